rns_mrc_to_int: RTL and testbench
=================================

// Module: rns_mrc_to_int
// PURPOSE
//  Sequential RNS-to-binary converter using mixed-radix conversion (MRC) with valid/ready handshakes.
//  Sits directly downstream of fir_rns: consumes its packed 4-residue output, emits a 32-bit integer.
//  Multi-cycle alternative to the combinational convertor_rns_to_int: small fixed-constant modular
//  multipliers are reused over 6 cycles instead of one wide CRT datapath.
// PARAMETERS
//  M0   233  modulus of residue lane 0, packed in in_rns[7:0]
//  M1   239  modulus of lane 1, in_rns[15:8]
//  M2   241  modulus of lane 2, in_rns[23:16]
//  M3   251  modulus of lane 3, in_rns[31:24]
//  Moduli are pairwise coprime and each <= 255; M0*M1*M2*M3 < 2^32.
//  Modular inverses inv(Mi mod Mj) are computed by constant function at elaboration.
// PORTS
//  clk       in   1   single clock, rising edge
//  rst_n     in   1   asynchronous, active-low reset
//  in_valid  in   1   in_rns holds a word to convert
//  in_ready  out  1   converter accepts a word this cycle
//  in_rns    in   32  packed residues {r3,r2,r1,r0}, 8 bits each
//  out_valid out  1   out_data holds a finished result
//  out_ready in   1   downstream consumes the result this cycle
//  out_data  out  32  converted integer; unsigned, or two's complement when SIGNED_OUT_EN is defined
// BEHAVIOUR
//  Reset: state IDLE; out_valid=0; out_data=0; all residue, digit and accumulator registers 0; in_ready=1.
//  States: IDLE -> MRC (3 cycles, step k=0..2) -> HORNER (3 cycles) -> OUT.
//  in_ready = (state==IDLE) | (state==OUT & out_ready). An accepted word (in_valid & in_ready at edge E0)
//    loads r0..r3. A lane value >= Mi is reduced by one subtraction of Mi on load.
//  MRC step k: d_k=r_k; for every j>k: r_j <= ((r_j - r_k) mod Mj) * inv(Mk mod Mj) mod Mj.
//    Negative difference: add Mj. Product: 16 bits, reduced mod Mj. After step 2: d3=r3.
//  HORNER: acc<=d3 on entry; then acc<=d2+M2*acc; acc<=d1+M1*acc; acc<=d0+M0*acc (32-bit, no overflow).
//  OUT: out_valid=1 and out_data=acc from edge E6 (6 clocks after acceptance). Both hold stable until
//    out_valid & out_ready.
//  OUT handshake: consumed and no new word -> IDLE, out_valid=0 next cycle. Consumed together with
//    in_valid -> new word loaded in the same edge, state MRC; back-to-back throughput is 1 result per 6 clocks.
//  in_valid outside IDLE/OUT is ignored; in_rns is sampled only at acceptance.
//  out_data is registered and keeps its last value after the handshake.
//  rst_n low mid-conversion: the operation is aborted immediately, with no partial result; all outputs
//    return to reset values.
// CONFIGURATION
//  SIGNED_OUT_EN defined: the result is interpreted symmetrically. acc >= (M+1)/2 outputs acc - M
//    (two's complement). One extra compare/subtract in the final HORNER cycle; latency unchanged.
//  SIGNED_OUT_EN undefined: out_data = acc, range 0..M-1.
//  M = M0*M1*M2*M3 = 3368562317 for the defaults.
// TESTING
//  1. Reset check: rst_n=0 -> out_valid=0, out_data=0, in_ready=1. Release; idle 5 clocks -> out_valid stays 0.
//  2. Value 1000: in_rns=0xF7242C44 accepted -> after 6 clocks out_valid=1, out_data=1000. With out_ready=1
//     -> IDLE next cycle.
//  3. Backpressure: in_rns=0x01010101 with out_ready=0 for 10 clocks -> out_data=1 held stable, in_ready=0.
//     Then out_ready=1 with in_valid and 0x00000000 -> next result 0, 6 clocks later.
//  4. Top of range: in_rns=0xFAF0EEE8 -> 3368562316 (0xC8C82E8C) unsigned; 0xFFFFFFFF with SIGNED_OUT_EN.
//     in_rns=0xF6ECEAE4 -> 0xC8C82E88 unsigned; 0xFFFFFFFB (-5) signed.
//  5. Abort: pulse rst_n low 3 clocks after accepting 0xF7242C44 -> out_valid=0, state IDLE.
//     Re-send the word -> 1000.
//  6. Stream: FIR outputs of 0..9 sent with random in_valid/out_ready -> results match the
//     convertor_rns_to_int golden model, in order, with none lost.

Source files
------------

// File: rtl/rns_mrc_to_int.sv
// rns_mrc_to_int: sequential RNS->binary converter (mixed-radix conversion + Horner), 6 clocks/word.
// Ports: clk, rst_n (async low), in_valid/in_ready/in_rns[31:0] {r3,r2,r1,r0}, out_valid/out_ready/out_data[31:0].
// Option: define SIGNED_OUT_EN for a symmetric two's-complement result.
module rns_mrc_to_int #(
  parameter int unsigned M0 = 233,
  parameter int unsigned M1 = 239,
  parameter int unsigned M2 = 241,
  parameter int unsigned M3 = 251
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_rns,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  function automatic int unsigned modinv(
    input int unsigned a,
    input int unsigned m
  );
    int unsigned r;
    r = 0;
    for (int unsigned x = 1; x < m; x++) begin
      if (r == 0 && ((a % m) * x) % m == 1) r = x;
    end
    return r;
  endfunction

  localparam logic [8:0] W0 = 9'(M0);
  localparam logic [8:0] W1 = 9'(M1);
  localparam logic [8:0] W2 = 9'(M2);
  localparam logic [8:0] W3 = 9'(M3);

  localparam logic [7:0] I01 = 8'(modinv(M0, M1));
  localparam logic [7:0] I02 = 8'(modinv(M0, M2));
  localparam logic [7:0] I03 = 8'(modinv(M0, M3));
  localparam logic [7:0] I12 = 8'(modinv(M1, M2));
  localparam logic [7:0] I13 = 8'(modinv(M1, M3));
  localparam logic [7:0] I23 = 8'(modinv(M2, M3));

  localparam logic [63:0] MT = 64'(M0) * 64'(M1) * 64'(M2) * 64'(M3);
  localparam logic [63:0] HT = (MT + 64'd1) >> 1;
  localparam logic [31:0] MM = MT[31:0];
  localparam logic [31:0] HALF = HT[31:0];

  // One MRC lane update: ((rj - rk) mod mj) * inv mod mj.
  // rk comes from a smaller-or-equal modulus lane, so one
  // subtraction brings it into range of mj.
  function automatic logic [7:0] mstep(
    input logic [7:0] rj,
    input logic [7:0] rk,
    input logic [8:0] mj,
    input logic [7:0] iv
  );
    logic [8:0]  a;
    logic [8:0]  b;
    logic [8:0]  d;
    logic [15:0] p;
    a = {1'b0, rk};
    if (a >= mj) a = a - mj;
    b = {1'b0, rj};
    d = (b >= a) ? b - a : b + mj - a;
    p = d[7:0] * iv;
    return 8'(p % {7'd0, mj});
  endfunction

  function automatic logic [7:0] red(
    input logic [7:0] v,
    input logic [8:0] m
  );
    logic [8:0] w;
    w = {1'b0, v};
    if (w >= m) w = w - m;
    return w[7:0];
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    MRC,
    HORNER,
    OUT
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [1:0]  step;
  logic [1:0]  step_n;
  logic        accept;
  logic [7:0]  r0;
  logic [7:0]  r1;
  logic [7:0]  r2;
  logic [7:0]  r3;
  logic [31:0] acc;
  logic [31:0] fin;
  logic [31:0] res;

  always_comb begin
    state_n  = state;
    step_n   = 2'd0;
    in_ready = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        in_ready = 1'b1;
        if (in_valid) state_n = MRC;
      end
      (state == MRC): begin
        step_n = step + 2'd1;
        if (step == 2'd2) begin
          step_n  = 2'd0;
          state_n = HORNER;
        end
      end
      (state == HORNER): begin
        step_n = step + 2'd1;
        if (step == 2'd2) begin
          step_n  = 2'd0;
          state_n = OUT;
        end
      end
      (state == OUT): begin
        in_ready = out_ready;
        if (out_ready) state_n = in_valid ? MRC : IDLE;
      end
      default: state_n = IDLE;
    endcase
    accept = in_valid & in_ready;
  end

  // Final Horner step; the signed fold shares the same cycle.
  always_comb begin
    fin = {24'd0, r0} + 32'(M0) * acc;
`ifdef SIGNED_OUT_EN
    res = (fin >= HALF) ? fin - MM : fin;
`else
    res = fin;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= 2'd0;
    end else begin
      state <= state_n;
      step  <= step_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0        <= 8'd0;
      r1        <= 8'd0;
      r2        <= 8'd0;
      r3        <= 8'd0;
      acc       <= 32'd0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
    end else begin
      if (state == OUT && out_ready) out_valid <= 1'b0;
      if (accept) begin
        r0 <= red(in_rns[7:0], W0);
        r1 <= red(in_rns[15:8], W1);
        r2 <= red(in_rns[23:16], W2);
        r3 <= red(in_rns[31:24], W3);
      end
      if (state == MRC) begin
        unique case (step)
          2'd0: begin
            r1 <= mstep(r1, r0, W1, I01);
            r2 <= mstep(r2, r0, W2, I02);
            r3 <= mstep(r3, r0, W3, I03);
          end
          2'd1: begin
            r2 <= mstep(r2, r1, W2, I12);
            r3 <= mstep(r3, r1, W3, I13);
          end
          default: begin
            r3  <= mstep(r3, r2, W3, I23);
            acc <= {24'd0, mstep(r3, r2, W3, I23)};
          end
        endcase
      end
      if (state == HORNER) begin
        unique case (step)
          2'd0: acc <= {24'd0, r2} + 32'(M2) * acc;
          2'd1: acc <= {24'd0, r1} + 32'(M1) * acc;
          default: begin
            acc       <= fin;
            out_data  <= res;
            out_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rns_mrc_to_int.sv
// tb_rns_mrc_to_int: scoreboard bench for rns_mrc_to_int.
// Directed cases, abort via reset, then a randomised handshake stream.
module tb_rns_mrc_to_int;

  localparam longint MT = 64'd3368562317;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rns;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] cur_exp;
  logic [31:0] sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_pop = 0;
  bit          rnd = 1'b0;

  always #5 clk = ~clk;

  rns_mrc_to_int dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rns   (in_rns),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Handshakes resolve at the next rising edge; judge them mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(sb.size() == 0), 32'd0);
        if (sb.size() > 0) begin
          check("result", out_data, sb.pop_front());
          n_pop++;
        end
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  function automatic logic [31:0] enc(input longint x);
    return {8'(x % 251), 8'(x % 241), 8'(x % 239), 8'(x % 233)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [31:0] w,
    input logic [31:0] e
  );
    bit acc;
    int n;
    n        = 0;
    acc      = 1'b0;
    cur_exp  = e;
    in_rns   = w;
    in_valid = 1'b1;
    while (!acc && n < 60) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int base;
    int nsent;
    longint x;
    int v;
    logic [31:0] e;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_rns    = 32'd0;
    cur_exp   = 32'd0;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      check("idle_out_valid", 32'(out_valid), 32'd0);
    end

    out_ready = 1'b1;
    send(32'hF7242C44, 32'd1000);
    wait_out(lat);
    check("lat_1000", 32'(lat), 32'd6);
    tick();
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b0;
    send(32'h01010101, 32'd1);
    wait_out(lat);
    check("lat_bp", 32'(lat), 32'd6);
    repeat (10) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", out_data, 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_rns    = 32'h00000000;
    cur_exp   = 32'd0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    check("lat_b2b", 32'(lat), 32'd6);
    tick();

`ifdef SIGNED_OUT_EN
    send(32'hFAF0EEE8, 32'hFFFFFFFF);
`else
    send(32'hFAF0EEE8, 32'hC8C82E8C);
`endif
    wait_out(lat);
    tick();
`ifdef SIGNED_OUT_EN
    send(32'hF6ECEAE4, 32'hFFFFFFFB);
`else
    send(32'hF6ECEAE4, 32'hC8C82E88);
`endif
    wait_out(lat);
    tick();

    // lane 0 carries 5 + 233: must reduce to 5
    send({8'd5, 8'd5, 8'd5, 8'd238}, 32'd5);
    wait_out(lat);
    tick();

    send(32'hF7242C44, 32'd1000);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    tick();
    rst_n = 1'b1;
    repeat (8) begin
      tick();
      check("abort_no_partial", 32'(out_valid), 32'd0);
    end
    send(32'hF7242C44, 32'd1000);
    wait_out(lat);
    check("lat_resend", 32'(lat), 32'd6);
    tick();

    base  = n_pop;
    nsent = 0;
    rnd   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v = i * 37 - 150;
      x = (v < 0) ? MT + longint'(v) : longint'(v);
`ifdef SIGNED_OUT_EN
      e = 32'(v);
`else
      e = 32'(x);
`endif
      repeat ($urandom_range(0, 3)) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      send(enc(x), e);
      nsent++;
    end
    for (int i = 0; i < 10; i++) begin
      x = longint'($urandom) % MT;
`ifdef SIGNED_OUT_EN
      e = (x >= (MT + 1) / 2) ? 32'(x - MT) : 32'(x);
`else
      e = 32'(x);
`endif
      send(enc(x), e);
      nsent++;
    end
    rnd       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && (sb.size() > 0 || out_valid); i++) tick();
    check("drain", 32'(sb.size()), 32'd0);
    check("stream_count", 32'(n_pop - base), 32'(nsent));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
